// File: rtl/pattern_scan_ctrl_if.sv
// Requester handshake and result bundle for pattern_scan_ctrl.
// Optional macro PATTERN_PROG_EN adds the programmable pattern input.
interface pattern_scan_ctrl_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       busy;
    logic       grant;
    logic       serial_bit;
    logic       match;
    logic       done;
    logic [2:0] count;
`ifdef PATTERN_PROG_EN
    logic [3:0] pattern;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, pattern,
        input  req0_ready, req1_ready, busy, grant, serial_bit,
        input  match, done, count
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, pattern,
        output req0_ready, req1_ready, busy, grant, serial_bit,
        output match, done, count
    );
`else
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, busy, grant, serial_bit,
        input  match, done, count
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, busy, grant, serial_bit,
        output match, done, count
    );
`endif
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Two-requester round-robin word serializer with a 4-bit Mealy pattern detector.
// Macro PATTERN_PROG_EN selects a programmable pattern; otherwise 4'b1101.
module pattern_scan_ctrl (
    input  logic                 clk,
    input  logic                 reset,
    pattern_scan_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_shreg;
    logic [3:0] r_window;
    logic [2:0] r_idx;
    logic [2:0] r_count;
    logic       r_grant;
    // 1 means req1 is favoured on a tie; reset value favours req0
    logic       r_prio;

    logic       w_win;
    logic       w_any;
    logic       w_hs;
    logic       w_ready0;
    logic       w_ready1;
    logic       w_sbit;
    logic       w_match;
    logic [3:0] w_cmp;
    logic [3:0] w_pat;
    logic [7:0] w_data;

`ifdef PATTERN_PROG_EN
    assign w_pat = bus.pattern;
`else
    assign w_pat = 4'b1101;
`endif

    assign w_any  = bus.req0_valid | bus.req1_valid;
    assign w_win  = bus.req1_valid & (~bus.req0_valid | r_prio);
    assign w_data = w_win ? bus.req1_data : bus.req0_data;
    assign w_cmp  = {r_window[2:0], r_shreg[7]};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, arbitration readies and detector outputs
    always_comb begin
        w_next   = r_state;
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        w_sbit   = 1'b0;
        w_match  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready0 = w_any & ~w_win & ~reset;
                w_ready1 = w_any & w_win & ~reset;
                if (w_any) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_sbit  = r_shreg[7];
                w_match = (r_idx >= 3'd3) && (w_cmp == w_pat);
                if (r_idx == 3'd7) begin
                    w_next = S_REPORT;
                end
            end
            S_REPORT: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_hs = w_ready0 | w_ready1;

    // Word capture on handshake, then shift/window/count during SHIFT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg  <= 8'd0;
            r_window <= 4'd0;
            r_idx    <= 3'd0;
            r_count  <= 3'd0;
            r_grant  <= 1'b0;
            r_prio   <= 1'b0;
        end else if (w_hs) begin
            r_shreg  <= w_data;
            r_window <= 4'd0;
            r_idx    <= 3'd0;
            r_count  <= 3'd0;
            r_grant  <= w_win;
            r_prio   <= ~w_win;
        end else if (r_state == S_SHIFT) begin
            r_shreg  <= {r_shreg[6:0], 1'b0};
            r_window <= w_cmp;
            r_idx    <= r_idx + 3'd1;
            if (w_match) begin
                r_count <= r_count + 3'd1;
            end
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_REPORT);
    assign bus.serial_bit = w_sbit;
    assign bus.match      = w_match;
    assign bus.count      = r_count;
    assign bus.grant      = r_grant;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl against a word-level reference model.
// Exercises the programmable pattern when PATTERN_PROG_EN is defined.
module tb_pattern_scan_ctrl;

    logic clk = 1'b0;
    logic reset;

    pattern_scan_ctrl_if bus();

    pattern_scan_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_total = 0;
    int         last_served;
    logic [3:0] tb_pat;

`ifdef PATTERN_PROG_EN
    assign bus.pattern = tb_pat;
`endif

    // Pattern hit at SHIFT cycle k: bits k-3..k of the word, MSB first.
    function automatic bit ref_hit(input logic [7:0] w, input logic [3:0] p,
                                   input int k);
        logic [7:0] s;
        s = w >> (7 - k);
        return (k >= 3) && (s[3:0] == p);
    endfunction

    function automatic int ref_count(input logic [7:0] w, input logic [3:0] p);
        int c = 0;
        for (int k = 0; k < 8; k++) c += int'(ref_hit(w, p, k));
        return c;
    endfunction

    // Round-robin: sole requester wins, else the one not served last.
    function automatic int ref_pick(input bit v0, input bit v1);
        if (v0 && v1) return (last_served == 0) ? 1 : 0;
        if (v1) return 1;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data = 8'hDA;
        bus.req1_data = 8'h0D;
        tick();
        tick();
        n_total++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b00)
            $display("FAIL reset_ready: got %b want 00",
                     {bus.req1_ready, bus.req0_ready});
        else n_pass++;
        n_total++;
        if ({bus.busy, bus.done, bus.match, bus.serial_bit} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.busy, bus.done, bus.match, bus.serial_bit});
        else n_pass++;
        n_total++;
        if ({bus.count, bus.grant} !== 4'b0000)
            $display("FAIL reset_count_grant: got %b want 0000",
                     {bus.count, bus.grant});
        else n_pass++;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset = 1'b0;
        last_served = -1;
        tick();
        n_total++;
        if (bus.busy !== 1'b0)
            $display("FAIL idle_after_reset: busy got %b want 0", bus.busy);
        else n_pass++;
    endtask

    // Serve one word from requester r and check every cycle of its lifetime.
    task automatic test_word(input int r, input logic [7:0] w);
        int         exp_cnt;
        logic [1:0] exp_rdy;
        exp_cnt = ref_count(w, tb_pat);
        exp_rdy = (r == 1) ? 2'b10 : 2'b01;
        bus.req0_valid = (r == 0);
        bus.req1_valid = (r == 1);
        bus.req0_data = (r == 0) ? w : 8'($urandom);
        bus.req1_data = (r == 1) ? w : 8'($urandom);
        #1;
        n_total++;
        if ({bus.req1_ready, bus.req0_ready} !== exp_rdy)
            $display("FAIL hs_ready: got %b want %b",
                     {bus.req1_ready, bus.req0_ready}, exp_rdy);
        else n_pass++;
        tick();
        last_served = r;
        bus.req0_data = 8'($urandom);
        bus.req1_data = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            bus.req0_valid = (r == 1) ? 1'($urandom) : 1'b0;
            bus.req1_valid = (r == 0) ? 1'($urandom) : 1'b0;
            #1;
            n_total++;
            if ({bus.busy, bus.done, bus.req1_ready, bus.req0_ready} !== 4'b1000)
                $display("FAIL shift_ctl c%0d: got %b want 1000", k,
                         {bus.busy, bus.done, bus.req1_ready, bus.req0_ready});
            else n_pass++;
            n_total++;
            if (bus.serial_bit !== w[7-k])
                $display("FAIL serial c%0d: got %b want %b", k,
                         bus.serial_bit, w[7-k]);
            else n_pass++;
            n_total++;
            if (bus.match !== ref_hit(w, tb_pat, k))
                $display("FAIL match c%0d w=%h p=%b: got %b want %b", k, w,
                         tb_pat, bus.match, ref_hit(w, tb_pat, k));
            else n_pass++;
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        n_total++;
        if ({bus.busy, bus.done, bus.match, bus.serial_bit} !== 4'b1100)
            $display("FAIL report_flags: got %b want 1100",
                     {bus.busy, bus.done, bus.match, bus.serial_bit});
        else n_pass++;
        n_total++;
        if (bus.count !== 3'(exp_cnt))
            $display("FAIL count w=%h p=%b: got %0d want %0d", w, tb_pat,
                     bus.count, exp_cnt);
        else n_pass++;
        n_total++;
        if (bus.grant !== 1'(r))
            $display("FAIL grant: got %b want %0d", bus.grant, r);
        else n_pass++;
        tick();
        n_total++;
        if ({bus.busy, bus.done, bus.count, bus.grant} !== {2'b00, 3'(exp_cnt), 1'(r)})
            $display("FAIL idle_hold: got %b want %b",
                     {bus.busy, bus.done, bus.count, bus.grant},
                     {2'b00, 3'(exp_cnt), 1'(r)});
        else n_pass++;
        tick();
        n_total++;
        if (bus.busy !== 1'b0)
            $display("FAIL idle_stay: busy got %b want 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_fixed_vectors();
        test_word(0, 8'b11011010);
        test_word(1, 8'h0D);
        test_word(1, 8'hFF);
    endtask

    task automatic test_reset_midword();
        logic seen;
        bus.req0_valid = 1'b1;
        bus.req0_data = 8'b11011010;
        tick();
        bus.req0_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        bus.req0_valid = 1'b1;
        #1;
        n_total++;
        if ({bus.busy, bus.done, bus.match, bus.serial_bit,
             bus.req1_ready, bus.req0_ready} !== 6'b0)
            $display("FAIL midreset_flags: got %b want 000000",
                     {bus.busy, bus.done, bus.match, bus.serial_bit,
                      bus.req1_ready, bus.req0_ready});
        else n_pass++;
        n_total++;
        if ({bus.count, bus.grant} !== 4'b0)
            $display("FAIL midreset_regs: got %b want 0000",
                     {bus.count, bus.grant});
        else n_pass++;
        tick();
        bus.req0_valid = 1'b0;
        reset = 1'b0;
        last_served = -1;
        seen = 1'b0;
        repeat (12) begin
            if (bus.done || bus.busy) seen = 1'b1;
            tick();
        end
        n_total++;
        if (seen !== 1'b0)
            $display("FAIL midreset_nodone: got %b want 0", seen);
        else n_pass++;
        test_word(0, 8'b11010000);
    endtask

    task automatic test_back_to_back();
        logic [7:0] q0[$];
        logic [7:0] q1[$];
        logic [7:0] sw[$];
        int         sr[$];
        int         cnt;
        int         ndone;
        int         pick;
        int         er;
        bit         v0;
        bit         v1;
        logic [7:0] ew;
        logic [1:0] exp_rdy;
        q0.push_back(8'($urandom));
        q0.push_back(8'($urandom));
        q1.push_back(8'($urandom));
        q1.push_back(8'($urandom));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_served = -1;
        cnt = 0;
        ndone = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            v0 = (q0.size() > 0);
            v1 = (q1.size() > 0);
            bus.req0_valid = v0;
            bus.req1_valid = v1;
            bus.req0_data = v0 ? q0[0] : 8'h00;
            bus.req1_data = v1 ? q1[0] : 8'h00;
            #1;
            exp_rdy = 2'b00;
            pick = -1;
            if (cnt == 0 && (v0 || v1)) begin
                pick = ref_pick(v0, v1);
                exp_rdy = (pick == 1) ? 2'b10 : 2'b01;
            end
            n_total++;
            if ({bus.req1_ready, bus.req0_ready} !== exp_rdy)
                $display("FAIL b2b_ready cyc%0d: got %b want %b", cyc,
                         {bus.req1_ready, bus.req0_ready}, exp_rdy);
            else n_pass++;
            n_total++;
            if (bus.done !== (cnt == 1))
                $display("FAIL b2b_done cyc%0d: got %b want %b", cyc,
                         bus.done, (cnt == 1));
            else n_pass++;
            if (cnt == 1) begin
                ndone++;
                ew = sw.pop_front();
                er = sr.pop_front();
                n_total++;
                if ({bus.grant, bus.count} !== {1'(er), 3'(ref_count(ew, tb_pat))})
                    $display("FAIL b2b_result #%0d: got g%b c%0d want g%0d c%0d",
                             ndone, bus.grant, bus.count, er,
                             ref_count(ew, tb_pat));
                else n_pass++;
            end
            if (pick >= 0) begin
                if (pick == 1) sw.push_back(q1.pop_front());
                else sw.push_back(q0.pop_front());
                sr.push_back(pick);
                last_served = pick;
                cnt = 9;
            end else if (cnt > 0) begin
                cnt--;
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        n_total++;
        if (ndone !== 4)
            $display("FAIL b2b_ndone: got %0d want 4", ndone);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
`ifdef PATTERN_PROG_EN
            tb_pat = 4'($urandom);
`endif
            test_word(int'($urandom_range(0, 1)), 8'($urandom));
        end
        tb_pat = 4'b1101;
    endtask

`ifdef PATTERN_PROG_EN
    task automatic test_prog();
        tb_pat = 4'b1111;
        test_word(0, 8'hFF);
        tb_pat = 4'b0000;
        test_word(1, 8'h00);
        tb_pat = 4'b1101;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data = 8'h00;
        bus.req1_data = 8'h00;
        tb_pat = 4'b1101;
        last_served = -1;
        test_reset();
        test_fixed_vectors();
        test_reset_midword();
        test_back_to_back();
        test_random();
`ifdef PATTERN_PROG_EN
        test_prog();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
